// File: rtl/tick_scheduler.sv
// Purpose : multi-channel clock-enable divider; each channel pulses tick_out[i] once every max(P,1) cycles.
// Latency : tick_out/ch_active are registered; config hits a disabled channel on the accept edge, an enabled one at its next wrap.
// Backpr. : cfg_ready = !pend_v[cfg_ch]; one pending update per channel. Optional sq_out via macro TICK_SCHED_SQUARE_EN.
module tick_scheduler #(
  parameter int                NUM_CH      = 4,
  parameter int                CNT_W       = 26,
  parameter int                DEFAULT_DIV = 50_000_000,
  parameter logic [NUM_CH-1:0] RST_EN      = NUM_CH'(1)
) (
  input  logic                                  clk_in,
  input  logic                                  rst_s_n,
  input  logic                                  cfg_valid,
  output logic                                  cfg_ready,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]                      cfg_period,
  input  logic                                  cfg_en,
  output logic [NUM_CH-1:0]                     tick_out,
  output logic [NUM_CH-1:0]                     ch_active
`ifdef TICK_SCHED_SQUARE_EN
  ,
  output logic [NUM_CH-1:0]                     sq_out
`endif
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // A zero period would never wrap, so it is stored as 1 everywhere.
  localparam logic [CNT_W-1:0] DEF_PER = (DEFAULT_DIV == 0) ? CNT_W'(1) : CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0]  per_q      [NUM_CH];
  logic [CNT_W-1:0]  per_d      [NUM_CH];
  logic [CNT_W-1:0]  cnt_q      [NUM_CH];
  logic [CNT_W-1:0]  cnt_d      [NUM_CH];
  logic [CNT_W-1:0]  pend_per_q [NUM_CH];
  logic [CNT_W-1:0]  pend_per_d [NUM_CH];
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] pend_en_q, pend_en_d;
  logic [NUM_CH-1:0] pend_v_q, pend_v_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] wrap, acc;
  logic [CNT_W-1:0]  wr_per;
`ifdef TICK_SCHED_SQUARE_EN
  logic [NUM_CH-1:0] sq_q, sq_d;
`endif

  assign wr_per = (cfg_period == '0) ? CNT_W'(1) : cfg_period;

  // Ready only looks at the addressed channel; out-of-range channels always accept and drop.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = !pend_v_q[i];
    end
  end

  // Per-channel wrap detect and write-accept decode.
  always_comb begin
    wrap = '0;
    acc  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wrap[i] = en_q[i] && (cnt_q[i] == per_q[i] - CNT_W'(1));
      acc[i]  = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
    end
  end

  // Next-state: count/wrap, immediate config for idle channels, deferred config at wrap for running ones.
  always_comb begin
    per_d      = per_q;
    cnt_d      = cnt_q;
    pend_per_d = pend_per_q;
    en_d       = en_q;
    pend_en_d  = pend_en_q;
    pend_v_d   = pend_v_q;
    tick_d     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (en_q[i]) begin
        if (wrap[i]) begin
          tick_d[i] = 1'b1;
          cnt_d[i]  = '0;
          if (pend_v_q[i]) begin
            per_d[i]    = pend_per_q[i];
            en_d[i]     = pend_en_q[i];
            pend_v_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
        // Accept implies pend_v_q was clear, so this never collides with the apply above;
        // an accept on the wrap edge therefore lands in the slot for the following wrap.
        if (acc[i]) begin
          pend_per_d[i] = wr_per;
          pend_en_d[i]  = cfg_en;
          pend_v_d[i]   = 1'b1;
        end
      end else begin
        cnt_d[i] = '0;
        if (acc[i]) begin
          per_d[i] = wr_per;
          en_d[i]  = cfg_en;
        end
      end
    end
  end

`ifdef TICK_SCHED_SQUARE_EN
  // Square output flips on every tick edge and idles low while the channel is off.
  always_comb begin
    sq_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (en_q[i]) sq_d[i] = tick_d[i] ? !sq_q[i] : sq_q[i];
    end
  end
`endif

  // State registers with synchronous active-low reset; reset drops any pending update.
  always_ff @(posedge clk_in) begin
    if (!rst_s_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        per_q[i]      <= DEF_PER;
        cnt_q[i]      <= '0;
        pend_per_q[i] <= '0;
      end
      en_q      <= RST_EN;
      pend_en_q <= '0;
      pend_v_q  <= '0;
      tick_q    <= '0;
`ifdef TICK_SCHED_SQUARE_EN
      sq_q      <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        per_q[i]      <= per_d[i];
        cnt_q[i]      <= cnt_d[i];
        pend_per_q[i] <= pend_per_d[i];
      end
      en_q      <= en_d;
      pend_en_q <= pend_en_d;
      pend_v_q  <= pend_v_d;
      tick_q    <= tick_d;
`ifdef TICK_SCHED_SQUARE_EN
      sq_q      <= sq_d;
`endif
    end
  end

  assign tick_out  = tick_q;
  assign ch_active = en_q;
`ifdef TICK_SCHED_SQUARE_EN
  assign sq_out    = sq_q;
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler: 4-channel instance plus a 3-channel instance for the
// out-of-range channel case. Edge numbers k count rising edges from the last reset edge;
// outputs are sampled on the falling edge after edge k.
module tb_tick_scheduler;

  logic       clk_in = 1'b0;
  logic       rst_s_n;
  logic       cfg_valid, cfg_ready, cfg_en;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_period;
  logic [3:0] tick_out, ch_active;
`ifdef TICK_SCHED_SQUARE_EN
  logic [3:0] sq_out;
`endif

  logic       c3_valid, c3_ready, c3_en;
  logic [1:0] c3_ch;
  logic [7:0] c3_period;
  logic [2:0] c3_tick, c3_active;
`ifdef TICK_SCHED_SQUARE_EN
  logic [2:0] c3_sq;
`endif

  int errors = 0;
  int checks = 0;
  int k      = 0;

  always #10 clk_in = ~clk_in;

  tick_scheduler #(.NUM_CH(4), .CNT_W(8), .DEFAULT_DIV(5), .RST_EN(4'b0001)) u_dut (
    .clk_in(clk_in), .rst_s_n(rst_s_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_en(cfg_en),
    .tick_out(tick_out), .ch_active(ch_active)
`ifdef TICK_SCHED_SQUARE_EN
    , .sq_out(sq_out)
`endif
  );

  tick_scheduler #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(5), .RST_EN(3'b001)) u_dut3 (
    .clk_in(clk_in), .rst_s_n(rst_s_n),
    .cfg_valid(c3_valid), .cfg_ready(c3_ready), .cfg_ch(c3_ch),
    .cfg_period(c3_period), .cfg_en(c3_en),
    .tick_out(c3_tick), .ch_active(c3_active)
`ifdef TICK_SCHED_SQUARE_EN
    , .sq_out(c3_sq)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_in);
    k++;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [7:0] p, input logic en);
    cfg_valid  = 1'b1;
    cfg_ch     = ch;
    cfg_period = p;
    cfg_en     = en;
  endtask

  function automatic logic [3:0] t4(input bit c0, input bit c1, input bit c2);
    return {1'b0, c2, c1, c0};
  endfunction

  initial begin
    rst_s_n = 1'b0; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_period = 8'd0; cfg_en = 1'b0;
    c3_valid = 1'b0; c3_ch = 2'd0; c3_period = 8'd0; c3_en = 1'b0;

    // Reset state
    @(negedge clk_in);
    @(negedge clk_in);
    chk("rst_tick", tick_out, 4'b0000);
    chk("rst_active", ch_active, 4'b0001);
    chk("rst_c3_active", c3_active, 3'b001);
    rst_s_n = 1'b1;
    k = 0;

    // Default period 5 on ch0 only
    for (int j = 1; j <= 10; j++) begin
      step();
      chk("default_tick", tick_out, t4(k % 5 == 0, 1'b0, 1'b0));
      chk("default_active", ch_active, 4'b0001);
    end

    // Write ch2 (disabled): P=3 applied on accept edge 11
    wr(2'd2, 8'd3, 1'b1);
    #1 chk("ch2_ready", cfg_ready, 1'b1);
    step();
    cfg_valid = 1'b0;
    chk("ch2_active", ch_active, 4'b0101);
    for (int j = 12; j <= 22; j++) begin
      step();
      chk("ch2_tick", tick_out, t4(k % 5 == 0, 1'b0, (k - 11) % 3 == 0));
`ifdef TICK_SCHED_SQUARE_EN
      chk("ch2_sq", sq_out[2], ((k - 11) / 3) % 2 == 1);
`endif
    end

    // ch0 P=2 mid-count (accept edge 23), second write stalled until wrap 25
    wr(2'd0, 8'd2, 1'b1);
    #1 chk("ch0_ready_first", cfg_ready, 1'b1);
    step();
    chk("defer_tick23", tick_out, t4(1'b0, 1'b0, 1'b1));
    wr(2'd1, 8'd9, 1'b1);
    #1 chk("ch1_ready_indep", cfg_ready, 1'b1);
    wr(2'd0, 8'd7, 1'b1);
    #1 chk("ch0_stall23", cfg_ready, 1'b0);
    step();
    chk("defer_tick24", tick_out, 4'b0000);
    #1 chk("ch0_stall24", cfg_ready, 1'b0);
    step();
    chk("defer_tick25", tick_out, t4(1'b1, 1'b0, 1'b0));
    #1 chk("ch0_ready_after_wrap", cfg_ready, 1'b1);
    cfg_valid = 1'b0;
    for (int j = 26; j <= 32; j++) begin
      step();
      chk("p2_tick", tick_out, t4((k - 25) % 2 == 0, 1'b0, (k - 11) % 3 == 0));
    end

    // ch0 disable, accepted on wrap edge 33: applies at wrap 35 after its final tick
    wr(2'd0, 8'd2, 1'b0);
    step();
    cfg_valid = 1'b0;
    chk("dis_tick33", tick_out, t4(1'b1, 1'b0, 1'b0));
    for (int j = 34; j <= 40; j++) begin
      step();
      chk("dis_tick", tick_out, t4(k == 35, 1'b0, (k - 11) % 3 == 0));
      chk("dis_active", ch_active, (k >= 35) ? 4'b0100 : 4'b0101);
    end

    // P=0 on ch1 behaves as P=1: tick every cycle from edge 42
    wr(2'd1, 8'd0, 1'b1);
    step();
    cfg_valid = 1'b0;
    chk("p0_active", ch_active, 4'b0110);
    for (int j = 42; j <= 46; j++) begin
      step();
      chk("p0_tick", tick_out, t4(1'b0, 1'b1, (k - 11) % 3 == 0));
    end

    // Pending update on ch2, then reset mid-run discards it
    wr(2'd2, 8'd5, 1'b1);
    step();
    cfg_valid = 1'b0;
    #1 chk("pend_ready_low", cfg_ready, 1'b0);
    rst_s_n = 1'b0;
    step();
    chk("midrst_tick", tick_out, 4'b0000);
    chk("midrst_active", ch_active, 4'b0001);
    #1 chk("midrst_ready", cfg_ready, 1'b1);
    rst_s_n = 1'b1;
    k = 0;
    for (int j = 1; j <= 10; j++) begin
      step();
      chk("post_rst_tick", tick_out, t4(k % 5 == 0, 1'b0, 1'b0));
    end

    // Out-of-range channel on 3-channel build: accepted and dropped
    c3_valid = 1'b1; c3_ch = 2'd3; c3_period = 8'd2; c3_en = 1'b1;
    #1 chk("oor_ready", c3_ready, 1'b1);
    step();
    c3_valid = 1'b0;
    chk("oor_active", c3_active, 3'b001);
    for (int j = 12; j <= 16; j++) begin
      step();
      chk("oor_tick", c3_tick, (k % 5 == 0) ? 3'b001 : 3'b000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Multi-channel tick scheduler built around a shared clock-enable divider: one `clk_in` domain, `NUM_CH` independent divide channels, each emitting a one-cycle `tick_out` pulse every P cycles. A valid/ready configuration port reprograms channel periods and enables at runtime. Updates to running channels are deferred to the channel's next wrap, so no runt or stretched period ever appears. The block replaces ad-hoc per-module `clk_div` instances: downstream logic uses `tick_out[i]` as a clock enable instead of a derived clock.

## Interface
- `NUM_CH`, 4, number of channels (1..16)
- `CNT_W`, 26, width of period and counter registers
- `DEFAULT_DIV`, 50_000_000, period loaded into every channel at reset (1 Hz at 50 MHz)
- `RST_EN`, 1, NUM_CH-bit mask of channels enabled at reset

Ports:
- `clk_in` in 1: system clock
- `rst_s_n` in 1: reset, synchronous, active-low
- `cfg_valid` in 1: config write request
- `cfg_ready` out 1: config write can be accepted
- `cfg_ch` in $clog2(NUM_CH) (min 1): target channel
- `cfg_period` in CNT_W: new period P
- `cfg_en` in 1: new enable for the channel
- `tick_out` out NUM_CH: registered one-cycle tick per channel
- `ch_active` out NUM_CH: registered current enable per channel
- `sq_out` out NUM_CH: present only with `TICK_SCHED_SQUARE_EN`

## Operation
- Per-channel state:
  - `per` (active period)
  - `cnt` (0..per-1)
  - `en`
  - pending slot `pend_per`/`pend_en` with flag `pend_v`
- Period rule: P=0 is stored as 1. The channel ticks every max(P,1) cycles.
- Running channel (`en`=1) on each edge:
  - If `cnt`==`per`-1: `tick_out[i]`<=1, `cnt`<=0 (wrap).
  - Otherwise: `cnt`<=`cnt`+1, `tick_out[i]`<=0.
- Disabled channel: `cnt` held 0, `tick_out[i]`=0.
- Accept condition: `cfg_valid` && `cfg_ready`. Outcome depends on target channel state:
  - Disabled: `per`<=P, `en`<=`cfg_en`, `cnt`<=0, applied on the accept edge.
  - Enabled: `pend_*`<=write, `pend_v`<=1.
- Deferred apply at a wrap edge of a channel with `pend_v`=1:
  - `per`<=`pend_per`, `en`<=`pend_en`, `pend_v`<=0, `cnt`<=0.
  - The wrap's own tick is still emitted.
  - If `pend_en`=0, the channel stops after that final tick.
- `cfg_ready` is combinational: `!pend_v[cfg_ch]`. One outstanding update per channel; further writes to it stall until it applies.
- `cfg_ch` >= NUM_CH: `cfg_ready`=1, write accepted and discarded.
- Accept on the same edge as that channel's wrap: the update goes to the pending slot and applies at the following wrap, not the current one.
- Writes to different channels are independent. `cfg_ready` never depends on other channels.

## Timing
- Reset values on the first edge with `rst_s_n`=0:
  - `tick_out`=0, `cnt`=0, `pend_v`=0, `sq_out`=0.
  - `per`=DEFAULT_DIV.
  - `en`=`ch_active`=RST_EN.
- Reset mid-operation discards pending updates. Counting restarts on the first edge after `rst_s_n` returns high.
- Channel started at edge E0 (out of reset, or accept to a disabled channel): `tick_out` high in the cycle after edges E0+P, E0+2P, …
- P=1: `tick_out` high continuously from edge E0+1.
- Deferred update: the new period counts from the apply edge W. The next tick follows edge W+Pnew.
- `ch_active` changes on the same edge as `en`.
- Config accept to state change: 0 cycles for a disabled channel (same edge). For an enabled channel, up to `per` cycles.

## Configuration
- `TICK_SCHED_SQUARE_EN` defined:
  - Adds port `sq_out`, toggled on every edge where `tick_out[i]` is set.
  - Result is a 50% duty square wave of period 2P.
  - `sq_out[i]` is forced to 0 when the channel is disabled.
  - `sq_out` resets to 0.
- Undefined: the port and its registers do not exist; all other behaviour is identical.

## Test plan
Sim parameters: NUM_CH=4, CNT_W=8, DEFAULT_DIV=5, RST_EN=4'b0001, 20 ns clock.
- Reset release: `tick_out[0]` pulses one cycle every 5 clocks; `tick_out[3:1]`=0; `ch_active`=4'b0001.
- Write ch2, P=3, en=1 (disabled channel): accepted immediately; first `tick_out[2]` 3 edges after accept, then every 3; `ch_active[2]`=1.
- Write ch0, P=2 mid-count: `cfg_ready` stays high on accept, then low for ch0 until the wrap. A second ch0 write is stalled. Old 5-cycle period completes with its tick, then ticks every 2.
- Write ch0 en=0: final tick at the next wrap, then `tick_out[0]`=0 and `ch_active[0]`=0.
- Edge cases:
  - P=0 to ch1: `tick_out[1]` continuously high.
  - `cfg_ch`=3 with NUM_CH=3 build: accepted, no state change.
  - `rst_s_n` low mid-run with a pending update: all outputs reach reset values on the next edge and the pending update is lost.
- With `TICK_SCHED_SQUARE_EN`, ch2 P=3: `sq_out[2]` is 3 cycles high / 3 cycles low, toggling on each tick edge.
